// File: rtl/obf_key_pkg.sv
// Shared types and constants for the obfuscation key loader.
// OBF_KEY_PARITY_EN appends an even-parity bit to every serial key.
package obf_key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

  localparam int NGATES_DEF = 5;
  localparam int KEY_W_DEF  = 2 * NGATES_DEF;

  // All ones: every camouflaged gate selects CONST0, so the core stays dead.
  localparam logic [KEY_W_DEF-1:0] LOCK_KEY = '1;

  localparam logic [1:0] SEL_PASS = 2'b00;
  localparam logic [1:0] SEL_INV  = 2'b01;
  localparam logic [1:0] SEL_ONE  = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

`ifdef OBF_KEY_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  function automatic int nbits_f(input int key_w);
    return key_w + (PARITY_EN ? 1 : 0);
  endfunction

endpackage

// File: rtl/obf_key_shreg.sv
// Shadow shift register, bit counter and parity accumulator for the key loader.
// With OBF_KEY_PARITY_EN the accumulator drives check_ok; otherwise check_ok is 1.
module obf_key_shreg #(
  parameter int KEY_W = 10,
  parameter int NBITS = 10,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             sin,
  output logic [KEY_W-1:0] key,
  output logic             done,
  output logic             check_ok
);

  localparam logic [CNT_W-1:0] NBITS_C = CNT_W'(NBITS);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(NBITS - 1);

  logic [NBITS-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  // Counter is compared before increment, so it saturates at NBITS.
  assign accept = shift_en && (cnt_q != NBITS_C);

  always_comb begin
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    if (clr) begin
      shadow_d = '0;
      cnt_d    = '0;
    end else if (accept) begin
      shadow_d = {shadow_q[NBITS-2:0], sin};
      cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      cnt_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
    end
  end

  // done flags that the next accepted bit completes the frame.
  assign done = (cnt_q == LAST_C);
  assign key  = shadow_q[NBITS-1 -: KEY_W];

`ifdef OBF_KEY_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (clr) begin
      par_d = 1'b0;
    end else if (accept) begin
      par_d = par_q ^ sin;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign check_ok = ~par_q;
`else
  assign check_ok = 1'b1;
`endif

endmodule

// File: rtl/obf_key_loader.sv
// Serial key loader driving the camouflaged-gate select bus D of an obfuscated netlist.
// OBF_KEY_PARITY_EN enables the trailing even-parity bit and the sticky KEY_ERR flag.
module obf_key_loader
  import obf_key_pkg::*;
#(
  parameter  int NGATES = NGATES_DEF,
  localparam int KEY_W  = 2 * NGATES
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             KEY_START,
  input  logic             KEY_SIN,
  input  logic             KEY_SVLD,
  input  logic             KEY_LOCK,
  output logic [KEY_W-1:0] D,
  output logic             KEY_VALID,
  output logic             KEY_BUSY,
  output logic             KEY_ERR
);

  localparam int               NBITS  = nbits_f(KEY_W);
  localparam int               CNT_W  = $clog2(KEY_W + 2);
  localparam logic [KEY_W-1:0] LOCK_D = '1;

  state_e           state_q, state_d;
  logic [KEY_W-1:0] d_q, d_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             clr, shift_en;
  logic [KEY_W-1:0] sh_key;
  logic             sh_done, check_ok;

  obf_key_shreg #(
    .KEY_W (KEY_W),
    .NBITS (NBITS),
    .CNT_W (CNT_W)
  ) u_shreg (
    .clk      (CLK),
    .rst_n    (RST_N),
    .clr      (clr),
    .shift_en (shift_en),
    .sin      (KEY_SIN),
    .key      (sh_key),
    .done     (sh_done),
    .check_ok (check_ok)
  );

  // KEY_LOCK outranks everything; D/KEY_VALID move only on lock or in CHECK.
  always_comb begin
    state_d  = state_q;
    d_d      = d_q;
    valid_d  = valid_q;
    clr      = 1'b0;
    shift_en = 1'b0;
    if (KEY_LOCK) begin
      state_d = ST_IDLE;
      d_d     = LOCK_D;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (KEY_START) begin
            state_d = ST_SHIFT;
            clr     = 1'b1;
          end
        end
        ST_SHIFT: begin
          if (KEY_START) begin
            clr = 1'b1;
          end else if (KEY_SVLD) begin
            shift_en = 1'b1;
            if (sh_done) begin
              state_d = ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          state_d = ST_IDLE;
          if (check_ok) begin
            d_d     = sh_key;
            valid_d = 1'b1;
          end else begin
            d_d     = LOCK_D;
            valid_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      d_q     <= LOCK_D;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign D         = d_q;
  assign KEY_VALID = valid_q;
  assign KEY_BUSY  = busy_q;

`ifdef OBF_KEY_PARITY_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (KEY_LOCK) begin
      err_d = 1'b0;
    end else if (state_q == ST_IDLE && KEY_START) begin
      err_d = 1'b0;
    end else if (state_q == ST_CHECK && !check_ok) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign KEY_ERR = err_q;
`else
  assign KEY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_obf_key_loader.sv
// Directed, table-driven bench for obf_key_loader (NGATES=5); honours OBF_KEY_PARITY_EN.
module tb_obf_key_loader;

  localparam int KW = 10;
`ifdef OBF_KEY_PARITY_EN
  localparam int NB = KW + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int NB = KW;
  localparam bit PAR = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          KEY_START, KEY_SIN, KEY_SVLD, KEY_LOCK;
  logic [KW-1:0] D;
  logic          KEY_VALID, KEY_BUSY, KEY_ERR;

  obf_key_loader #(.NGATES(5)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .KEY_START (KEY_START),
    .KEY_SIN   (KEY_SIN),
    .KEY_SVLD  (KEY_SVLD),
    .KEY_LOCK  (KEY_LOCK),
    .D         (D),
    .KEY_VALID (KEY_VALID),
    .KEY_BUSY  (KEY_BUSY),
    .KEY_ERR   (KEY_ERR)
  );

  always #5 CLK = ~CLK;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [KW-1:0] exp_d;
  logic          exp_valid, exp_err;

  typedef struct {
    string         name;
    logic [KW-1:0] key;
    logic          par;
    bit            alt;
    bit            ok_par;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [KW-1:0] ed, input logic ev,
                         input logic eb, input logic ee);
    chk({tag, "_d"}, 32'(D), 32'(ed));
    chk({tag, "_valid"}, 32'(KEY_VALID), 32'(ev));
    chk({tag, "_busy"}, 32'(KEY_BUSY), 32'(eb));
    chk({tag, "_err"}, 32'(KEY_ERR), 32'(ee));
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_bits(input string tag, input logic [KW-1:0] key, input logic par,
                           input bit alt);
    logic [KW:0] frame;
    logic        b;
    frame = {key, par};
    for (int i = NB - 1; i >= 0; i--) begin
      if (PAR) b = frame[i];
      else     b = key[i];
      if (alt) begin
        KEY_SVLD = 1'b0;
        KEY_SIN  = ~b;
        tick();
      end
      KEY_SVLD = 1'b1;
      KEY_SIN  = b;
      tick();
      if (i == NB - 2) chk_out({tag, "_mid"}, exp_d, exp_valid, 1'b1, 1'b0);
    end
    KEY_SVLD = 1'b0;
    KEY_SIN  = 1'b0;
  endtask

  task automatic finish_load(input string tag, input logic [KW-1:0] key, input bit ok);
    chk_out({tag, "_chk"}, exp_d, exp_valid, 1'b1, 1'b0);
    tick();
    if (ok) begin
      exp_d = key; exp_valid = 1'b1; exp_err = 1'b0;
    end else begin
      exp_d = '1; exp_valid = 1'b0; exp_err = 1'b1;
    end
    chk_out({tag, "_done"}, exp_d, exp_valid, 1'b0, exp_err);
  endtask

  task automatic load_key(input string tag, input logic [KW-1:0] key, input logic par,
                          input bit alt, input bit ok);
    KEY_START = 1'b1;
    tick();
    KEY_START = 1'b0;
    exp_err   = 1'b0;
    chk_out({tag, "_start"}, exp_d, exp_valid, 1'b1, 1'b0);
    send_bits(tag, key, par, alt);
    finish_load(tag, key, ok);
  endtask

  initial begin
    bit ok;
    vecs[0] = '{"k101_badpar", 10'h101, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{"k101",        10'h101, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{"k155_alt",    10'h155, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{"k000",        10'h000, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{"k3ff_alt",    10'h3FF, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{"k2aa_badpar", 10'h2AA, 1'b0, 1'b0, 1'b0};

    RST_N = 1'b0; KEY_START = 1'b0; KEY_SIN = 1'b0; KEY_SVLD = 1'b0; KEY_LOCK = 1'b0;
    exp_d = '1; exp_valid = 1'b0; exp_err = 1'b0;
    #12;
    chk_out("in_reset", 10'h3FF, 1'b0, 1'b0, 1'b0);
    #10 RST_N = 1'b1;
    repeat (5) tick();
    chk_out("idle", 10'h3FF, 1'b0, 1'b0, 1'b0);

    for (int v = 0; v < 6; v++) begin
      ok = PAR ? vecs[v].ok_par : 1'b1;
      load_key(vecs[v].name, vecs[v].key, vecs[v].par, vecs[v].alt, ok);
      repeat (2) tick();
      chk_out({vecs[v].name, "_hold"}, exp_d, exp_valid, 1'b0, exp_err);
    end

    // Restart mid-load; SVLD alongside START must be ignored both times.
    load_key("pre", 10'h000, 1'b0, 1'b0, 1'b1);
    KEY_START = 1'b1; KEY_SVLD = 1'b1; KEY_SIN = 1'b1;
    tick();
    KEY_START = 1'b0;
    repeat (4) tick();
    KEY_SVLD = 1'b0;
    chk_out("rs_partial", 10'h000, 1'b1, 1'b1, 1'b0);
    KEY_START = 1'b1; KEY_SVLD = 1'b1; KEY_SIN = 1'b1;
    tick();
    KEY_START = 1'b0; KEY_SVLD = 1'b0;
    chk_out("rs_restart", 10'h000, 1'b1, 1'b1, 1'b0);
    send_bits("rs", 10'h2AA, 1'b1, 1'b0);
    finish_load("rs", 10'h2AA, 1'b1);

    // Lock on the same cycle as the CHECK commit.
    KEY_START = 1'b1;
    tick();
    KEY_START = 1'b0;
    send_bits("lk", 10'h155, 1'b1, 1'b0);
    chk_out("lk_chk", 10'h2AA, 1'b1, 1'b1, 1'b0);
    KEY_LOCK = 1'b1;
    tick();
    KEY_LOCK = 1'b0;
    exp_d = '1; exp_valid = 1'b0; exp_err = 1'b0;
    chk_out("lk_done", 10'h3FF, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    chk_out("lk_hold", 10'h3FF, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a shift.
    load_key("pre_rst", 10'h101, 1'b0, 1'b0, 1'b1);
    KEY_START = 1'b1;
    tick();
    KEY_START = 1'b0;
    KEY_SVLD = 1'b1; KEY_SIN = 1'b0;
    repeat (3) tick();
    KEY_SVLD = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    chk_out("rst_mid", 10'h3FF, 1'b0, 1'b0, 1'b0);
    #3 RST_N = 1'b1;
    exp_d = '1; exp_valid = 1'b0; exp_err = 1'b0;
    repeat (3) tick();
    chk_out("rst_after", 10'h3FF, 1'b0, 1'b0, 1'b0);
    load_key("post_rst", 10'h155, 1'b1, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/obf_key_loader.md
# obf_key_loader

Serial key loader that feeds the camouflaged-gate select inputs (`D_0`..`D_{2·NGATES-1}`) of an obfuscated netlist such as `c432`. A key is loaded MSB-first over a qualified serial port, optionally checked, then committed atomically to a held parallel key bus. Until a valid key is committed, the bus carries the lock value: all ones, so every camouflaged gate selects CONST0. This keeps the protected core non-functional until it is keyed.

## Interface
- `NGATES`, 5: number of camouflaged gates; each gate takes a 2-bit select (00 pass, 01 invert, 10 CONST1, 11 CONST0).
- `KEY_W`, 2*NGATES: key width, derived and not overridable.
- `CLK` input 1: single clock, rising edge.
- `RST_N` input 1: asynchronous, active-low reset.
- `KEY_START` input 1: one-cycle request to begin a load.
- `KEY_SIN` input 1: serial key bit.
- `KEY_SVLD` input 1: qualifies `KEY_SIN` in the current cycle.
- `KEY_LOCK` input 1: synchronous re-lock request.
- `D` output KEY_W: committed key; `D[i]` drives netlist input `D_i`.
- `KEY_VALID` output 1: high while `D` holds a committed key.
- `KEY_BUSY` output 1: high while a load is in progress.
- `KEY_ERR` output 1: sticky flag for a failed check; cleared by the next `KEY_START` or `KEY_LOCK`.

## Operation
- Reset values: `D`=all ones, `KEY_VALID`=0, `KEY_BUSY`=0, `KEY_ERR`=0, state IDLE, shadow register 0, counter 0.
- States: IDLE, SHIFT, CHECK.
- IDLE
  - `KEY_START` → SHIFT.
  - On entry to SHIFT: clear the counter and shadow register, and clear `KEY_ERR`.
  - `KEY_SVLD` is ignored in IDLE, including in the same cycle as `KEY_START`.
- SHIFT
  - Each cycle with `KEY_SVLD`=1: shadow <= {shadow[N-2:0], KEY_SIN}, counter++.
  - `KEY_SVLD`=0: hold.
  - When counter reaches NBITS (KEY_W, or KEY_W+1 with parity): → CHECK.
  - The first bit received lands in `D[KEY_W-1]`.
- CHECK (one cycle)
  - Pass: `D` <= key portion of the shadow register, `KEY_VALID`=1.
  - Fail: `D` <= all ones, `KEY_VALID`=0, `KEY_ERR`=1.
  - Either way: → IDLE.
- `KEY_BUSY`=1 exactly in SHIFT and CHECK.
- `D` and `KEY_VALID` change only in CHECK or on `KEY_LOCK`. A load in progress never disturbs the previously committed key.
- `KEY_START` while in SHIFT restarts the load: counter and shadow are cleared, and any bit presented in that same cycle is discarded. `D` and `KEY_VALID` are unchanged.
- `KEY_START` in CHECK is ignored.
- `KEY_LOCK` has the highest priority, from any state: `D`=all ones, `KEY_VALID`=0, `KEY_ERR`=0, → IDLE. It wins over a simultaneous `KEY_START` or CHECK commit.
- Counter width is $clog2(KEY_W+2). The counter never wraps: it is compared before increment, and bits beyond NBITS cannot occur because SHIFT is exited.

## Timing
- `KEY_START` sampled at edge 0 → `KEY_BUSY`=1 after edge 0.
- The first bit can be sampled at edge 1.
- With `KEY_SVLD` held high, the last bit is sampled at edge NBITS and CHECK occupies cycle NBITS+1. `D` and `KEY_VALID` update at edge NBITS+1, and `KEY_BUSY` falls at that same edge.
- Gaps in `KEY_SVLD` add cycles one-for-one.
- All outputs are registered; there is no combinational path from input to output.
- Assertion of `RST_N` mid-load: outputs take their reset values immediately. Deassertion is synchronised by the integrator.

## Configuration
- `OBF_KEY_PARITY_EN` defined
  - NBITS = KEY_W+1; the last serial bit is an even-parity bit.
  - CHECK fails if the XOR of all KEY_W+1 bits is 1.
- Undefined
  - NBITS = KEY_W; CHECK always passes.
  - `KEY_ERR` is tied to 0.

## Structure
- Package `obf_key_pkg` holds:
  - the state enum;
  - the lock constant (all ones of width KEY_W);
  - the select encodings (SEL_PASS=2'b00, SEL_INV=2'b01, SEL_ONE=2'b10, SEL_ZERO=2'b11);
  - the NBITS derivation.
- Sub-module `obf_key_shreg` contains the shadow shift register, bit counter and parity accumulator, with a `done` output. The top level holds the FSM and the output register.

## Test plan
- Reset, then idle 5 cycles → `D`=10'h3FF, `KEY_VALID`=0, `KEY_BUSY`=0.
- NGATES=5, no parity: START, then bits 0,1,0,0,0,0,0,0,0,1 continuous → at edge 11, `D`=10'b0100000001, `KEY_VALID`=1, `KEY_BUSY`=0.
- Parity on: key 10'b0100000001 followed by parity bit 1 → `KEY_ERR`=1, `KEY_VALID`=0, `D`=10'h3FF. Repeat with parity bit 0 → committed, `KEY_ERR`=0.
- With key 10'h000 committed: START, shift 4 bits, START again, then shift 10 bits of 10'h2AA → `D` stays 10'h000 until the second load commits, then 10'h2AA.
- `KEY_SVLD` toggling every other cycle with key 10'h155 → commit after 20 accepted-plus-idle cycles, `D`=10'h155.
- `KEY_LOCK` in the same cycle as CHECK commit → `D`=10'h3FF, `KEY_VALID`=0; also `RST_N` low mid-shift → all outputs reset immediately.
